vga_framebuffer_db: RTL and testbench

//  Parametrised, double-buffered VGA framebuffer, single clock domain. CPU

---
 rtl/vga_framebuffer_db.sv | 183 ++++++++++++++++++
 tb/tb_vga_framebuffer_db.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer_db.sv
// Double-buffered VGA framebuffer: CPU stores go to the back buffer, scan-out reads the front buffer.
// Reads take 2 cycles, clear takes WORDS cycles; stores are dropped (not stalled) while o_busy is high.
module vga_framebuffer_db #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int BPP        = 4,
  parameter int DOUBLE_BUF = 1,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [31:0]    i_wrAddr,
  input  logic [31:0]    i_wrData,
  input  logic           i_memWrite,
  input  logic [1:0]     i_size,
  input  logic           en_MEM,
  input  logic           i_clrReq,
  input  logic [BPP-1:0] i_clrColor,
  input  logic           i_swapReq,
  input  logic           i_vblank,
  input  logic           i_rdEn,
  input  logic [XW-1:0]  i_pxlX,
  input  logic [YW-1:0]  i_pxlY,
  output logic [BPP-1:0] o_value,
  output logic           o_valid,
  output logic           o_busy,
  output logic           o_frontSel
);
  localparam int PPW   = 32 / BPP;
  localparam int WORDS = (WIDTH * HEIGHT + PPW - 1) / PPW;
  localparam int NBUF  = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int DEPTH = NBUF * WORDS;
  localparam int RAW   = $clog2(DEPTH);
  localparam int WAW   = $clog2(WORDS);
  localparam int LW    = $clog2(PPW);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [WAW-1:0]   ctr_q, ctr_d;
  logic [BPP-1:0]   clr_color_q, clr_color_d;
  logic             front_sel_q, front_sel_d;
  logic             pending_q, pending_d;
  logic             vblank_q, vblank_d;
  logic             rd_vld1_q, rd_vld1_d, rd_inr1_q, rd_inr1_d;
  logic [LW-1:0]    rd_lane1_q, rd_lane1_d;
  logic [RAW-1:0]   rd_addr1_q, rd_addr1_d;
  logic             rd_vld2_q, rd_vld2_d, rd_inr2_q, rd_inr2_d;
  logic [LW-1:0]    rd_lane2_q, rd_lane2_d;
  logic [31:0]      rd_word_q;

  logic             dbuf_en, back_sel, rd_sel, swap_any, store_ok;
  logic             we;
  logic [RAW-1:0]   waddr;
  logic [31:0]      wdata;
  logic [3:0]       wbe;
  logic [31:0]      rd_idx;

  logic [31:0]      mem [DEPTH];

  function automatic logic [RAW-1:0] buf_addr(input logic sel, input logic [WAW-1:0] word);
    return RAW'(32'(sel) * 32'(WORDS) + 32'(word));
  endfunction

  assign dbuf_en  = (DOUBLE_BUF != 0);
  assign back_sel = dbuf_en & ~front_sel_q;
  assign rd_sel   = dbuf_en & front_sel_q;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    clr_color_d = clr_color_q;
    case (state_q)
      IDLE: begin
        if (i_clrReq) begin
          state_d     = CLEAR;
          ctr_d       = '0;
          clr_color_d = i_clrColor;
        end
      end
      CLEAR: begin
        if (ctr_q == WAW'(WORDS - 1)) state_d = IDLE;
        else                          ctr_d   = ctr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear starting this cycle wins over a vblank-coincident swap; the swap stays pending.
  always_comb begin
    vblank_d    = i_vblank;
    swap_any    = dbuf_en & (pending_q | i_swapReq);
    pending_d   = swap_any;
    front_sel_d = front_sel_q;
    if (swap_any && (state_q == IDLE) && !i_clrReq && i_vblank && !vblank_q) begin
      front_sel_d = ~front_sel_q;
      pending_d   = 1'b0;
    end
  end

  always_comb begin
    store_ok = i_memWrite & en_MEM & (state_q == IDLE) & (i_size != 2'b11)
             & (i_wrAddr < 32'(4 * WORDS));
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    wbe   = '0;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = buf_addr(back_sel, ctr_q);
      wdata = {PPW{clr_color_q}};
      wbe   = 4'hF;
    end else if (store_ok) begin
      we    = 1'b1;
      waddr = buf_addr(back_sel, i_wrAddr[WAW+1:2]);
      case (i_size)
        2'b00:   begin wdata = {4{i_wrData[7:0]}};  wbe = 4'b0001 << i_wrAddr[1:0]; end
        2'b01:   begin wdata = {2{i_wrData[15:0]}}; wbe = i_wrAddr[1] ? 4'b1100 : 4'b0011; end
        default: begin wdata = i_wrData;            wbe = 4'hF; end
      endcase
    end
  end

  // Out-of-range pixels read word 0 of the buffer; their value is forced to zero at the output.
  always_comb begin
    rd_idx     = 32'(i_pxlY) * 32'(WIDTH) + 32'(i_pxlX);
    rd_vld1_d  = i_rdEn;
    rd_inr1_d  = (32'(i_pxlX) < 32'(WIDTH)) && (32'(i_pxlY) < 32'(HEIGHT));
    rd_lane1_d = LW'(rd_idx % 32'(PPW));
    rd_addr1_d = rd_inr1_d ? buf_addr(rd_sel, WAW'(rd_idx / 32'(PPW))) : '0;
    rd_vld2_d  = rd_vld1_q;
    rd_inr2_d  = rd_inr1_q;
    rd_lane2_d = rd_lane1_q;
  end

  always_ff @(posedge i_clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rd_word_q <= mem[rd_addr1_q];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      clr_color_q <= '0;
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
      vblank_q    <= 1'b0;
      rd_vld1_q   <= 1'b0;
      rd_inr1_q   <= 1'b0;
      rd_lane1_q  <= '0;
      rd_addr1_q  <= '0;
      rd_vld2_q   <= 1'b0;
      rd_inr2_q   <= 1'b0;
      rd_lane2_q  <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      clr_color_q <= clr_color_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
      vblank_q    <= vblank_d;
      rd_vld1_q   <= rd_vld1_d;
      rd_inr1_q   <= rd_inr1_d;
      rd_lane1_q  <= rd_lane1_d;
      rd_addr1_q  <= rd_addr1_d;
      rd_vld2_q   <= rd_vld2_d;
      rd_inr2_q   <= rd_inr2_d;
      rd_lane2_q  <= rd_lane2_d;
    end
  end

  assign o_value    = (rd_vld2_q && rd_inr2_q) ? rd_word_q[32'(rd_lane2_q) * BPP +: BPP] : '0;
  assign o_valid    = rd_vld2_q;
  assign o_busy     = (state_q == CLEAR);
  assign o_frontSel = front_sel_q;

endmodule

// File: tb/tb_vga_framebuffer_db.sv
// Directed bench: 160x120x4bpp double-buffered instance plus an 8x4x8bpp single-buffer instance.
module tb_vga_framebuffer_db;
  logic clk, rst_n;
  int   checks, errors;

  // instance A: defaults (160x120, 4 bpp, double buffered)
  logic [31:0] a_wrAddr, a_wrData;
  logic        a_memWrite, a_en, a_clrReq, a_swapReq, a_vblank, a_rdEn;
  logic [1:0]  a_size;
  logic [3:0]  a_clrColor, a_o_value;
  logic [7:0]  a_pxlX;
  logic [6:0]  a_pxlY;
  logic        a_o_valid, a_o_busy, a_o_frontSel;

  // instance B: 8x4, 8 bpp, single buffer
  logic [31:0] b_wrAddr, b_wrData;
  logic        b_memWrite, b_en, b_clrReq, b_swapReq, b_vblank, b_rdEn;
  logic [1:0]  b_size;
  logic [7:0]  b_clrColor, b_o_value;
  logic [2:0]  b_pxlX;
  logic [1:0]  b_pxlY;
  logic        b_o_valid, b_o_busy, b_o_frontSel;

  vga_framebuffer_db dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wrAddr(a_wrAddr), .i_wrData(a_wrData),
    .i_memWrite(a_memWrite), .i_size(a_size), .en_MEM(a_en), .i_clrReq(a_clrReq),
    .i_clrColor(a_clrColor), .i_swapReq(a_swapReq), .i_vblank(a_vblank), .i_rdEn(a_rdEn),
    .i_pxlX(a_pxlX), .i_pxlY(a_pxlY), .o_value(a_o_value), .o_valid(a_o_valid),
    .o_busy(a_o_busy), .o_frontSel(a_o_frontSel)
  );

  vga_framebuffer_db #(.WIDTH(8), .HEIGHT(4), .BPP(8), .DOUBLE_BUF(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wrAddr(b_wrAddr), .i_wrData(b_wrData),
    .i_memWrite(b_memWrite), .i_size(b_size), .en_MEM(b_en), .i_clrReq(b_clrReq),
    .i_clrColor(b_clrColor), .i_swapReq(b_swapReq), .i_vblank(b_vblank), .i_rdEn(b_rdEn),
    .i_pxlX(b_pxlX), .i_pxlY(b_pxlY), .o_value(b_o_value), .o_valid(b_o_valid),
    .o_busy(b_o_busy), .o_frontSel(b_o_frontSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st_a(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    a_wrAddr = addr; a_wrData = data; a_size = size; a_memWrite = 1'b1; a_en = 1'b1;
    tick;
    a_memWrite = 1'b0;
  endtask

  task automatic rd_a(input int x, input int y, input logic [3:0] exp, input string tag);
    a_rdEn = 1'b1; a_pxlX = 8'(x); a_pxlY = 7'(y);
    tick;
    a_rdEn = 1'b0;
    chk({tag, "_lat"}, 32'(a_o_valid), 32'd0);
    tick;
    chk({tag, "_vld"}, 32'(a_o_valid), 32'd1);
    chk({tag, "_val"}, 32'(a_o_value), 32'(exp));
  endtask

  task automatic st_b(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    b_wrAddr = addr; b_wrData = data; b_size = size; b_memWrite = 1'b1; b_en = 1'b1;
    tick;
    b_memWrite = 1'b0;
  endtask

  task automatic rd_b(input int x, input int y, input logic [7:0] exp, input string tag);
    b_rdEn = 1'b1; b_pxlX = 3'(x); b_pxlY = 2'(y);
    tick;
    b_rdEn = 1'b0;
    tick;
    chk({tag, "_vld"}, 32'(b_o_valid), 32'd1);
    chk({tag, "_val"}, 32'(b_o_value), 32'(exp));
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    a_wrAddr = '0; a_wrData = '0; a_memWrite = 0; a_en = 0; a_clrReq = 0; a_swapReq = 0;
    a_vblank = 0; a_rdEn = 0; a_size = '0; a_clrColor = '0; a_pxlX = '0; a_pxlY = '0;
    b_wrAddr = '0; b_wrData = '0; b_memWrite = 0; b_en = 0; b_clrReq = 0; b_swapReq = 0;
    b_vblank = 0; b_rdEn = 0; b_size = '0; b_clrColor = '0; b_pxlX = '0; b_pxlY = '0;
    tick; tick; tick;
    chk("rst_value", 32'(a_o_value), 32'd0);
    chk("rst_valid", 32'(a_o_valid), 32'd0);
    chk("rst_busy",  32'(a_o_busy), 32'd0);
    chk("rst_front", 32'(a_o_frontSel), 32'd0);
    rst_n = 1'b1;
    tick;

    // stores into back buffer 1
    st_a(32'd0,  32'h76543210, 2'b10);
    st_a(32'd4,  32'h11111111, 2'b10);
    st_a(32'd5,  32'h000000AB, 2'b00);
    st_a(32'd4,  32'hFFFFFFFF, 2'b11);
    st_a(32'd8,  32'h00000000, 2'b10);
    st_a(32'd11, 32'h0000BEEF, 2'b01);
    st_a(32'd12, 32'h00000000, 2'b10);
    a_wrAddr = 32'd12; a_wrData = 32'h99999999; a_size = 2'b10; a_memWrite = 1; a_en = 0;
    tick;
    a_memWrite = 0;
    st_a(32'd9596, 32'h80000000, 2'b10);
    st_a(32'd9600, 32'hDEADBEEF, 2'b10);

    // swap waits for vblank rise
    a_swapReq = 1; tick; a_swapReq = 0; tick; tick;
    chk("swap_wait", 32'(a_o_frontSel), 32'd0);
    a_vblank = 1; tick;
    chk("swap_vb", 32'(a_o_frontSel), 32'd1);
    a_vblank = 0; tick; a_vblank = 1; tick;
    chk("swap_once", 32'(a_o_frontSel), 32'd1);
    a_vblank = 0; tick;

    for (int i = 0; i < 8; i++) rd_a(i, 0, 4'(i), "word_px");
    rd_a(8, 0, 4'h1, "sz11_px8");
    rd_a(9, 0, 4'h1, "byte_px9");
    rd_a(10, 0, 4'hB, "byte_px10");
    rd_a(11, 0, 4'hA, "byte_px11");
    rd_a(12, 0, 4'h1, "byte_px12");
    rd_a(16, 0, 4'h0, "half_px16");
    rd_a(20, 0, 4'hF, "half_px20");
    rd_a(21, 0, 4'hE, "half_px21");
    rd_a(23, 0, 4'hB, "half_px23");
    rd_a(24, 0, 4'h0, "enmem_px24");
    rd_a(159, 119, 4'h8, "last_px");
    rd_a(160, 0, 4'h0, "oor_x");
    rd_a(0, 120, 4'h0, "oor_y");

    // clear of back buffer 0 with simultaneous swap request
    a_clrReq = 1; a_clrColor = 4'hC; a_swapReq = 1;
    tick;
    a_clrReq = 0; a_swapReq = 0;
    n = 0;
    while (a_o_busy && n < 3000) begin
      if (n == 100) begin a_clrReq = 1; a_clrColor = 4'h3; end
      if (n == 101) a_clrReq = 0;
      if (n == 200) a_vblank = 1;
      if (n == 300) a_vblank = 0;
      n++;
      tick;
    end
    chk("clr_cycles", 32'(n), 32'd2400);
    chk("clr_front_held", 32'(a_o_frontSel), 32'd1);
    a_vblank = 1; tick;
    chk("swap_after_clr", 32'(a_o_frontSel), 32'd0);
    a_vblank = 0; tick;
    rd_a(0, 0, 4'hC, "clr_px0");
    rd_a(7, 0, 4'hC, "clr_px7");
    rd_a(80, 60, 4'hC, "clr_mid");
    rd_a(159, 119, 4'hC, "clr_last");

    // swap request coincident with vblank rise
    a_swapReq = 1; a_vblank = 1; tick;
    a_swapReq = 0;
    chk("swap_same_edge", 32'(a_o_frontSel), 32'd1);
    a_vblank = 0; tick;
    rd_a(1, 0, 4'h1, "front_kept");

    // single-buffer 8 bpp instance
    st_b(32'd4, 32'h44332211, 2'b10);
    rd_b(5, 0, 8'h22, "b_word_px5");
    st_b(32'd7, 32'h0000005E, 2'b00);
    rd_b(7, 0, 8'h5E, "b_byte_px7");
    rd_b(4, 0, 8'h11, "b_byte_px4");
    b_swapReq = 1; b_vblank = 1; tick;
    b_swapReq = 0; b_vblank = 0; tick;
    chk("b_no_swap", 32'(b_o_frontSel), 32'd0);
    b_clrReq = 1; b_clrColor = 8'h9A; tick;
    b_clrReq = 0;
    n = 0;
    while (b_o_busy && n < 100) begin
      n++;
      tick;
    end
    chk("b_clr_cycles", 32'(n), 32'd8);
    rd_b(3, 3, 8'h9A, "b_clr_px");
    rd_b(5, 0, 8'h9A, "b_clr_front");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
